matrix_scan_decoder: RTL and testbench
======================================

Name: matrix_scan_decoder

Overview:
- Receive-side counterpart of the LED matrix driver. Watches the row-select and column-drive lines the driver produces and rebuilds the displayed frame into a readable buffer.
- Used as an on-chip loopback/self-check block and as a capture front-end for chained matrix designs.
- Double-buffered: a frame becomes readable only once every row has been captured since the last row-0 capture.

Parameters:
- ROWS, 8, number of matrix rows (width of one-hot row_sel); ROWS >= 2.
- COLS, 8, number of matrix columns (width of col_data and rd_data).
- SETTLE, 2, consecutive clock edges row_sel must hold one value before its column data is captured; SETTLE >= 1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- row_sel  input  ROWS  one-hot active-high row select from the driver
- col_data  input  COLS  active-high column drive from the driver
- clr_err  input  1  synchronous clear of err_multi
- rd_row  input  $clog2(ROWS)  display-buffer read address
- rd_data  output  COLS  display-buffer row at rd_row (combinational read)
- frame_valid  output  1  one-cycle pulse: new frame committed to display buffer
- frame_count  output  8  committed-frame counter, wraps 255->0
- err_multi  output  1  sticky: more than one row_sel bit seen high

Behaviour:
- Reset (rst=1 at an edge) clears the following:
  - input registers, stable counter, captured-row mask, working buffer and display buffer (all zero);
  - frame_valid=0, frame_count=0, err_multi=0;
  - therefore rd_data=0.
- Reset mid-frame discards all partial capture.
- Input stage: row_sel and col_data are registered once (row_q, col_q) at every edge.
- Stable counter:
  - reset to 1 when row_q changes value;
  - otherwise increments, saturating at SETTLE.
- Capture condition: counter reaches SETTLE on this edge (transition into SETTLE), and row_q is exactly one-hot.
  - At most one capture per dwell; a longer hold does not recapture.
- Capture timing:
  - Let k be the first edge at which a new row_sel value is registered.
  - With the value held through edge k+SETTLE-1, col_q from edge k+SETTLE-1 is written at edge k+SETTLE.
  - The write goes into working buffer [index of row_q].
  - A row held for fewer than SETTLE edges is never captured.
- row_q all-zero (blanking): no capture, counter still tracks changes.
- row_q with two or more bits set: no capture, err_multi<=1 at the edge the condition is registered.
  - err_multi holds until rst or clr_err=1.
  - If clr_err=1 on the same edge as a new multi-hot detection, the set wins.
- Captured-row mask:
  - Capture of row 0 sets mask to row-0 bit only; this starts a new frame and discards prior partial state.
  - Capture of any other row sets that row's bit in the mask.
  - Rows may arrive in any order after row 0; a repeated row overwrites its earlier data.
- Commit:
  - Triggered on the edge after a capture that makes the mask all ones.
  - Working buffer copies to display buffer, frame_valid=1 for exactly one cycle, frame_count increments, mask clears.
  - Frame_valid therefore asserts at edge k+SETTLE+1 relative to the last row's first-registered edge k.
  - A capture on the commit edge goes into the working buffer and is not lost.
- Read: rd_data = display[rd_row]. rd_row >= ROWS returns 0.
- ROWS=1 is illegal; elaboration must fail on SETTLE=0.

Optional Feature:
- Macro: MATRIX_SCAN_DECODER_CRC_EN.
- Defined: adds output frame_crc [7:0], which is the CRC-8 of the committed frame.
  - Polynomial 0x07, init 0x00, no reflection, no final XOR.
  - Computed over rows 0..ROWS-1 in order, each row's COLS bits MSB first.
  - Updated in the same cycle frame_valid pulses; reset value 0x00.
  - Computation is sequential over the working buffer or incremental; the visible result must be valid whenever frame_valid=1.
- Undefined: no frame_crc port, no CRC logic.

Test Plan:
- Reset: assert rst 3 cycles with random inputs. Expect rd_data=0 for all rd_row, frame_valid=0, frame_count=0, err_multi=0.
- Full scan, SETTLE=2: row_sel=1<<i for 4 cycles each, i=0..7, col_data=8'hA0+i. Expect one frame_valid pulse 3 edges after row 7 first registered, rd_data[i]=8'hA0+i, frame_count=1. A second identical scan gives frame_count=2.
- Glitch rejection: hold row 3 for 1 cycle with col_data=8'hFF inside an otherwise valid scan (row 3 also legitimately held 4 cycles with 8'h33). Expect rd_data[3]=8'h33 and exactly one frame_valid.
- Multi-hot: row_sel=8'h03 for 4 cycles. Expect err_multi=1, no capture, still 1 after 20 cycles. Pulse clr_err and expect err_multi=0 next cycle.
- Reset mid-frame: scan rows 0..3, assert rst, then run a full scan with 8'h5A data. Expect rd_data all 8'h5A and frame_count=1.
- CRC (macro defined): all-zero frame gives frame_crc=0x00. Pattern 8'hA0+i gives frame_crc equal to the bench's CRC-8/0x07 model at the frame_valid cycle.

Source files
------------

// File: rtl/matrix_scan_decoder.sv
// Rebuilds a scanned LED-matrix frame from row_sel/col_data into a display buffer.
// Define MATRIX_SCAN_DECODER_CRC_EN to add frame_crc (CRC-8/0x07 of each frame).
module matrix_scan_decoder #(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int SETTLE = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ROWS-1:0]         row_sel,
  input  logic [COLS-1:0]         col_data,
  input  logic                    clr_err,
  input  logic [$clog2(ROWS)-1:0] rd_row,
  output logic [COLS-1:0]         rd_data,
  output logic                    frame_valid,
  output logic [7:0]              frame_count,
  output logic                    err_multi
`ifdef MATRIX_SCAN_DECODER_CRC_EN
  ,
  output logic [7:0]              frame_crc
`endif
);

  localparam int IW = $clog2(ROWS);
  localparam int CW =
    (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0] CMAX = CW'(SETTLE);
  localparam logic [CW-1:0] CPRE = CW'(SETTLE - 1);

  if (ROWS < 2) begin : g_bad_rows
    $error("ROWS must be >= 2");
  end
  if (SETTLE < 1) begin : g_bad_settle
    $error("SETTLE must be >= 1");
  end

  logic [ROWS-1:0]           row_q;
  logic [COLS-1:0]           col_q;
  logic [CW-1:0]             cnt;
  logic                      arm;
  logic                      commit;
  logic [ROWS-1:0]           mask;
  logic [ROWS-1:0][COLS-1:0] work;
  logic [ROWS-1:0][COLS-1:0] disp;

  logic                      row_chg;
  logic                      multi_in;
  logic                      cap;
  logic                      arm_nx;
  logic [IW-1:0]             cap_idx;
  logic [ROWS-1:0]           mask_nx;

  always_comb begin
    row_chg  = (row_sel != row_q);
    multi_in = ($countones(row_sel) > 1);
    cap      = arm & $onehot(row_q);
    cap_idx  = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (row_q[i]) cap_idx = IW'(i);
    end
    // arm marks the edge where the dwell counter first hits SETTLE
    arm_nx = row_chg ? (SETTLE == 1)
                     : (cnt == CPRE);
    mask_nx = commit ? '0 : mask;
    if (cap) begin
      if (cap_idx == '0) mask_nx = ROWS'(1);
      else mask_nx[cap_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q       <= '0;
      col_q       <= '0;
      cnt         <= '0;
      arm         <= 1'b0;
      commit      <= 1'b0;
      mask        <= '0;
      work        <= '0;
      disp        <= '0;
      frame_valid <= 1'b0;
      frame_count <= '0;
      err_multi   <= 1'b0;
    end else begin
      row_q <= row_sel;
      col_q <= col_data;
      if (row_chg) cnt <= CW'(1);
      else if (cnt != CMAX) cnt <= cnt + 1'b1;
      arm    <= arm_nx;
      mask   <= mask_nx;
      commit <= cap & (&mask_nx);
      frame_valid <= commit;
      if (commit) begin
        disp        <= work;
        frame_count <= frame_count + 8'd1;
      end
      if (cap) work[cap_idx] <= col_q;
      err_multi <= multi_in |
                   (err_multi & ~clr_err);
    end
  end

  always_comb begin
    rd_data = '0;
    if (32'(rd_row) < ROWS)
      rd_data = disp[rd_row];
  end

`ifdef MATRIX_SCAN_DECODER_CRC_EN
  logic [7:0] crc_nx;
  logic       fb;

  always_comb begin
    crc_nx = '0;
    fb     = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      for (int b = COLS - 1; b >= 0; b--) begin
        fb     = crc_nx[7] ^ work[r][b];
        crc_nx = {crc_nx[6:0], 1'b0} ^
                 (fb ? 8'h07 : 8'h00);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) frame_crc <= '0;
    else if (commit) frame_crc <= crc_nx;
  end
`endif

endmodule

// File: tb/tb_matrix_scan_decoder.sv
// Randomised and directed bench for matrix_scan_decoder against a frame-level model.
`timescale 1ns/100ps
module tb_matrix_scan_decoder;
  localparam int ROWS   = 8;
  localparam int COLS   = 8;
  localparam int SETTLE = 2;
  localparam int IW     = $clog2(ROWS);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [ROWS-1:0] row_sel = '0;
  logic [COLS-1:0] col_data = '0;
  logic            clr_err = 1'b0;
  logic [IW-1:0]   rd_row = '0;
  logic [COLS-1:0] rd_data;
  logic            frame_valid;
  logic [7:0]      frame_count;
  logic            err_multi;
`ifdef MATRIX_SCAN_DECODER_CRC_EN
  logic [7:0]      frame_crc;
`endif

  matrix_scan_decoder #(
    .ROWS(ROWS), .COLS(COLS), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .rst(rst),
    .row_sel(row_sel), .col_data(col_data),
    .clr_err(clr_err), .rd_row(rd_row),
    .rd_data(rd_data),
    .frame_valid(frame_valid),
    .frame_count(frame_count),
    .err_multi(err_multi)
`ifdef MATRIX_SCAN_DECODER_CRC_EN
    , .frame_crc(frame_crc)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int ecnt = 0;
  int fv_cnt = 0;
  int fv_edge = 0;
  int k7 = 0;

  // Frame-level model: dwell length per value, pending capture/commit events
  logic [COLS-1:0] m_work [ROWS];
  logic [COLS-1:0] m_disp [ROWS];
  bit              m_seen [ROWS];
  logic [ROWS-1:0] m_prev;
  int              m_run;
  bit              m_cap;
  int              m_cap_idx;
  logic [COLS-1:0] m_cap_col;
  bit              m_commit;
  bit              m_fv;
  int              m_fc;
  bit              m_err;
  logic [7:0]      m_crc;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(logic [ROWS-1:0] v);
    int r = 0;
    for (int i = 0; i < ROWS; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Polynomial long division of the augmented frame bitstream by 0x107
  function automatic logic [7:0] crc_model();
    logic [8:0] w = '0;
    for (int r = 0; r < ROWS; r++)
      for (int b = COLS - 1; b >= 0; b--) begin
        w = {w[7:0], m_work[r][b]};
        if (w[8]) w = w ^ 9'h107;
      end
    for (int z = 0; z < 8; z++) begin
      w = {w[7:0], 1'b0};
      if (w[8]) w = w ^ 9'h107;
    end
    return w[7:0];
  endfunction

  task automatic model_edge(input logic [ROWS-1:0] row,
                            input logic [COLS-1:0] col,
                            input logic clr,
                            input logic r);
    bit all;
    if (r) begin
      for (int i = 0; i < ROWS; i++) begin
        m_work[i] = '0; m_disp[i] = '0; m_seen[i] = 0;
      end
      m_prev = '0; m_run = 0; m_cap = 0; m_cap_idx = 0;
      m_cap_col = '0; m_commit = 0; m_fv = 0; m_fc = 0;
      m_err = 0; m_crc = '0;
      return;
    end
    m_fv = m_commit;
    if (m_commit) begin
      m_crc = crc_model();
      for (int i = 0; i < ROWS; i++) begin
        m_disp[i] = m_work[i]; m_seen[i] = 0;
      end
      m_fc = (m_fc + 1) % 256;
    end
    m_commit = 0;
    if (m_cap) begin
      if (m_cap_idx == 0)
        for (int i = 0; i < ROWS; i++) m_seen[i] = 0;
      m_seen[m_cap_idx] = 1;
      m_work[m_cap_idx] = m_cap_col;
      all = 1;
      for (int i = 0; i < ROWS; i++) all &= m_seen[i];
      m_commit = all;
    end
    if (row == m_prev) m_run++;
    else m_run = 1;
    m_prev = row;
    m_cap = (m_run == SETTLE) && ($countones(row) == 1);
    m_cap_idx = idx_of(row);
    m_cap_col = col;
    if ($countones(row) > 1) m_err = 1;
    else if (clr) m_err = 0;
  endtask

  task automatic compare();
    logic [COLS-1:0] er;
    er = (int'(rd_row) < ROWS) ? m_disp[rd_row] : '0;
    chk("frame_valid", 32'(frame_valid), 32'(m_fv));
    chk("frame_count", 32'(frame_count), 32'(m_fc));
    chk("err_multi", 32'(err_multi), 32'(m_err));
    chk("rd_data", 32'(rd_data), 32'(er));
`ifdef MATRIX_SCAN_DECODER_CRC_EN
    chk("frame_crc", 32'(frame_crc), 32'(m_crc));
`endif
    if (frame_valid === 1'b1) begin
      fv_cnt++;
      fv_edge = ecnt;
    end
  endtask

  task automatic cyc(input logic [ROWS-1:0] row,
                     input logic [COLS-1:0] col,
                     input logic clr,
                     input logic r);
    row_sel = row; col_data = col;
    clr_err = clr; rst = r;
    rd_row = IW'($urandom_range(0, ROWS - 1));
    @(posedge clk);
    ecnt++;
    model_edge(row, col, clr, r);
    #1;
    compare();
  endtask

  function automatic logic [COLS-1:0] dat(int kind, int i);
    case (kind)
      0: return COLS'(8'hA0 + i);
      1: return COLS'(8'h11 * i);
      2: return COLS'(8'h5A);
      default: return '0;
    endcase
  endfunction

  task automatic peek_all(input int kind);
    for (int i = 0; i < ROWS; i++) begin
      rd_row = IW'(i);
      #0.5;
      chk($sformatf("peek_row%0d", i),
          32'(rd_data), 32'(dat(kind, i)));
    end
  endtask

  task automatic scan(input int kind, input int hi);
    for (int i = 0; i <= hi; i++) begin
      if (kind == 1 && i == 2)
        cyc(ROWS'(1) << 3, '1, 1'b0, 1'b0);
      if (i == hi) k7 = ecnt + 1;
      repeat (4)
        cyc(ROWS'(1) << i, dat(kind, i), 1'b0, 1'b0);
    end
  endtask

  task automatic blank(input int n);
    repeat (n)
      cyc('0, COLS'($urandom), 1'b0, 1'b0);
  endtask

  initial begin
    int f0;
    int h;
    int sel;
    int nr;
    logic [ROWS-1:0] v;

    repeat (3)
      cyc(ROWS'($urandom), COLS'($urandom),
          1'($urandom), 1'b1);
    chk("rst_count", 32'(frame_count), 0);
    chk("rst_err", 32'(err_multi), 0);
    chk("rst_fv", 32'(frame_valid), 0);
    peek_all(3);

    f0 = fv_cnt;
    scan(0, ROWS - 1); blank(4);
    chk("scan1_pulses", fv_cnt - f0, 1);
    chk("scan1_latency", fv_edge - k7, SETTLE + 1);
    chk("scan1_count", 32'(frame_count), 1);
    peek_all(0);

    scan(0, ROWS - 1); blank(4);
    chk("scan2_count", 32'(frame_count), 2);

    f0 = fv_cnt;
    scan(1, ROWS - 1); blank(4);
    chk("glitch_pulses", fv_cnt - f0, 1);
    rd_row = IW'(3);
    #0.5;
    chk("glitch_row3", 32'(rd_data), 32'h33);
    chk("glitch_count", 32'(frame_count), 3);

    repeat (4) cyc(ROWS'(3), '1, 1'b0, 1'b0);
    chk("multi_set", 32'(err_multi), 1);
    blank(20);
    chk("multi_sticky", 32'(err_multi), 1);
    cyc('0, '0, 1'b1, 1'b0);
    chk("multi_clr", 32'(err_multi), 0);
    chk("multi_count", 32'(frame_count), 3);

    scan(0, 3);
    cyc('0, '0, 1'b0, 1'b1);
    scan(2, ROWS - 1); blank(4);
    chk("midrst_count", 32'(frame_count), 1);
    peek_all(2);

    nr = 0;
    repeat (150) begin
      h   = $urandom_range(1, 4);
      sel = $urandom_range(0, 99);
      if (sel < 70) begin
        nr = (nr + 1) % ROWS;
        v = ROWS'(1) << nr;
      end else if (sel < 80) begin
        v = ROWS'(1) << $urandom_range(0, ROWS - 1);
      end else if (sel < 93) begin
        v = '0;
      end else begin
        v = ROWS'(3) << $urandom_range(0, ROWS - 2);
      end
      repeat (h)
        cyc(v, COLS'($urandom),
            1'($urandom_range(0, 49) == 0),
            1'($urandom_range(0, 199) == 0));
    end

`ifdef MATRIX_SCAN_DECODER_CRC_EN
    cyc('0, '0, 1'b0, 1'b1);
    scan(3, ROWS - 1); blank(4);
    chk("crc_zero", 32'(frame_crc), 0);
    chk("crc_zero_count", 32'(frame_count), 1);
    scan(0, ROWS - 1); blank(4);
    chk("crc_a0_count", 32'(frame_count), 2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
